// File: rtl/stopwatch_core.sv
// Stopwatch timekeeping datapath with STOP/RUN/CLEAR control.
// The divided tick is sampled as data and only its rising edge advances time.
module stopwatch_core #(
    parameter int MSEC_MAX = 100,
    parameter int SEC_MAX  = 60,
    parameter int MIN_MAX  = 60,
    parameter int HOUR_MAX = 24
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_tick,
    input  logic       i_run_stop,
    input  logic       i_clear,
    output logic [6:0] o_msec,
    output logic [5:0] o_sec,
    output logic [5:0] o_min,
    output logic [4:0] o_hour,
    output logic       o_running,
    output logic       o_rollover
);

    localparam logic [6:0] MSEC_LAST = 7'(MSEC_MAX - 1);
    localparam logic [5:0] SEC_LAST  = 6'(SEC_MAX - 1);
    localparam logic [5:0] MIN_LAST  = 6'(MIN_MAX - 1);
    localparam logic [4:0] HOUR_LAST = 5'(HOUR_MAX - 1);

    typedef enum logic [1:0] {
        ST_STOP  = 2'd0,
        ST_RUN   = 2'd1,
        ST_CLEAR = 2'd2
    } state_t;

    state_t     state_r, state_s;
    logic       tick_d_r, tick_edge_s, count_s, zero_s;
    logic       running_r, rollover_r, rollover_s;
    logic [6:0] msec_r, msec_s;
    logic [5:0] sec_r, sec_s;
    logic [5:0] min_r, min_s;
    logic [4:0] hour_r, hour_s;

    assign tick_edge_s = i_tick & ~tick_d_r;
    assign count_s     = (state_r == ST_RUN) & tick_edge_s;
    // Zero on the edge entering CLEAR and keep zero while in it.
    assign zero_s      = ((state_r == ST_STOP) & i_clear) | (state_r == ST_CLEAR);

    // Next-state logic; clear has priority over run/stop only from STOP.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_STOP: begin
                if (i_clear) begin
                    state_s = ST_CLEAR;
                end else if (i_run_stop) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_STOP;
                end
            end
            ST_RUN: begin
                if (i_run_stop) begin
                    state_s = ST_STOP;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_CLEAR: state_s = ST_STOP;
            default:  state_s = ST_STOP;
        endcase
    end

    // Field update with same-cycle carry chain through all four fields.
    always_comb begin
        msec_s     = msec_r;
        sec_s      = sec_r;
        min_s      = min_r;
        hour_s     = hour_r;
        rollover_s = 1'b0;
        if (zero_s) begin
            msec_s = 7'd0;
            sec_s  = 6'd0;
            min_s  = 6'd0;
            hour_s = 5'd0;
        end else if (count_s) begin
            if (msec_r >= MSEC_LAST) begin
                msec_s = 7'd0;
                if (sec_r >= SEC_LAST) begin
                    sec_s = 6'd0;
                    if (min_r >= MIN_LAST) begin
                        min_s = 6'd0;
                        if (hour_r >= HOUR_LAST) begin
                            hour_s     = 5'd0;
                            rollover_s = 1'b1;
                        end else begin
                            hour_s = hour_r + 5'd1;
                        end
                    end else begin
                        min_s = min_r + 6'd1;
                    end
                end else begin
                    sec_s = sec_r + 6'd1;
                end
            end else begin
                msec_s = msec_r + 7'd1;
            end
        end else begin
            rollover_s = 1'b0;
        end
    end

    // State, edge-detect history, fields and status flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= ST_STOP;
            tick_d_r   <= 1'b0;
            running_r  <= 1'b0;
            rollover_r <= 1'b0;
            msec_r     <= 7'd0;
            sec_r      <= 6'd0;
            min_r      <= 6'd0;
            hour_r     <= 5'd0;
        end else begin
            state_r    <= state_s;
            tick_d_r   <= i_tick;
            running_r  <= (state_s == ST_RUN);
            rollover_r <= rollover_s;
            msec_r     <= msec_s;
            sec_r      <= sec_s;
            min_r      <= min_s;
            hour_r     <= hour_s;
        end
    end

    assign o_msec     = msec_r;
    assign o_sec      = sec_r;
    assign o_min      = min_r;
    assign o_hour     = hour_r;
    assign o_running  = running_r;
    assign o_rollover = rollover_r;

endmodule

// File: tb/tb_stopwatch_core.sv
// Directed bench for stopwatch_core: a default-modulus instance for the main
// sequences and a short-modulus instance that reaches full-scale wrap quickly.
module tb_stopwatch_core;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       a_tick = 1'b0, a_rs = 1'b0, a_clr = 1'b0;
    logic       b_tick = 1'b0, b_rs = 1'b0, b_clr = 1'b0;
    logic [6:0] a_msec, b_msec;
    logic [5:0] a_sec, a_min, b_sec, b_min;
    logic [4:0] a_hour, b_hour;
    logic       a_running, a_rollover, b_running, b_rollover;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    stopwatch_core dut_a (
        .clk(clk), .rst(rst_n), .i_tick(a_tick), .i_run_stop(a_rs), .i_clear(a_clr),
        .o_msec(a_msec), .o_sec(a_sec), .o_min(a_min), .o_hour(a_hour),
        .o_running(a_running), .o_rollover(a_rollover)
    );

    // Max time is 1:1:2.99, i.e. 1200 centiseconds per full wrap.
    stopwatch_core #(.MSEC_MAX(100), .SEC_MAX(3), .MIN_MAX(2), .HOUR_MAX(2)) dut_b (
        .clk(clk), .rst(rst_n), .i_tick(b_tick), .i_run_stop(b_rs), .i_clear(b_clr),
        .o_msec(b_msec), .o_sec(b_sec), .o_min(b_min), .o_hour(b_hour),
        .o_running(b_running), .o_rollover(b_rollover)
    );

    typedef struct {
        string      name;
        logic       rs;
        logic       clr;
        int         ticks;
        logic [6:0] msec;
        logic [5:0] sec;
        logic [5:0] min;
        logic [4:0] hour;
        logic       running;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_a(input string name, input int msec, input int sec, input int min,
                         input int hour, input int running);
        chk({name, ".msec"}, int'(a_msec), msec);
        chk({name, ".sec"}, int'(a_sec), sec);
        chk({name, ".min"}, int'(a_min), min);
        chk({name, ".hour"}, int'(a_hour), hour);
        chk({name, ".running"}, int'(a_running), running);
        chk({name, ".rollover"}, int'(a_rollover), 0);
    endtask

    task automatic cyc_a(input logic rs, input logic clr, input logic tk);
        a_rs = rs; a_clr = clr; a_tick = tk;
        @(negedge clk);
    endtask

    task automatic ticks_a(input int n);
        for (int i = 0; i < n; i++) begin
            cyc_a(1'b0, 1'b0, 1'b1);
            cyc_a(1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic cyc_b(input logic rs, input logic clr, input logic tk);
        b_rs = rs; b_clr = clr; b_tick = tk;
        @(negedge clk);
    endtask

    int roll_seen;

    initial begin
        //           name        rs    clr   ticks msec   sec   min   hour  run
        vecs[0]  = '{"reset",    1'b0, 1'b0, 0,    7'd0,  6'd0, 6'd0, 5'd0, 1'b0};
        vecs[1]  = '{"run250",   1'b1, 1'b0, 250,  7'd50, 6'd2, 6'd0, 5'd0, 1'b1};
        vecs[2]  = '{"clr_run",  1'b0, 1'b1, 0,    7'd50, 6'd2, 6'd0, 5'd0, 1'b1};
        vecs[3]  = '{"stop",     1'b1, 1'b0, 0,    7'd50, 6'd2, 6'd0, 5'd0, 1'b0};
        vecs[4]  = '{"stop_tk",  1'b0, 1'b0, 30,   7'd50, 6'd2, 6'd0, 5'd0, 1'b0};
        vecs[5]  = '{"clear",    1'b0, 1'b1, 0,    7'd0,  6'd0, 6'd0, 5'd0, 1'b0};
        vecs[6]  = '{"rerun7",   1'b1, 1'b0, 7,    7'd7,  6'd0, 6'd0, 5'd0, 1'b1};
        vecs[7]  = '{"stop7",    1'b1, 1'b0, 0,    7'd7,  6'd0, 6'd0, 5'd0, 1'b0};
        vecs[8]  = '{"clr_rs",   1'b1, 1'b1, 0,    7'd0,  6'd0, 6'd0, 5'd0, 1'b0};
        vecs[9]  = '{"still_st", 1'b0, 1'b0, 5,    7'd0,  6'd0, 6'd0, 5'd0, 1'b0};
        vecs[10] = '{"run5",     1'b1, 1'b0, 5,    7'd5,  6'd0, 6'd0, 5'd0, 1'b1};

        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Full-scale wrap on the short-modulus instance.
        cyc_b(1'b1, 1'b0, 1'b0);
        cyc_b(1'b0, 1'b0, 1'b0);
        roll_seen = 0;
        for (int i = 0; i < 1199; i++) begin
            cyc_b(1'b0, 1'b0, 1'b1);
            roll_seen += int'(b_rollover);
            cyc_b(1'b0, 1'b0, 1'b0);
            roll_seen += int'(b_rollover);
        end
        chk("b_max.msec", int'(b_msec), 99);
        chk("b_max.sec", int'(b_sec), 2);
        chk("b_max.min", int'(b_min), 1);
        chk("b_max.hour", int'(b_hour), 1);
        chk("b_early_rollover", roll_seen, 0);
        cyc_b(1'b0, 1'b0, 1'b1);
        chk("b_wrap.msec", int'(b_msec), 0);
        chk("b_wrap.sec", int'(b_sec), 0);
        chk("b_wrap.min", int'(b_min), 0);
        chk("b_wrap.hour", int'(b_hour), 0);
        chk("b_wrap.rollover", int'(b_rollover), 1);
        cyc_b(1'b0, 1'b0, 1'b0);
        chk("b_after.rollover", int'(b_rollover), 0);
        chk("b_after.running", int'(b_running), 1);

        // Table: pulse cycle, idle cycle (lets CLEAR finish), then tick edges.
        for (int v = 0; v < 11; v++) begin
            cyc_a(vecs[v].rs, vecs[v].clr, 1'b0);
            cyc_a(1'b0, 1'b0, 1'b0);
            ticks_a(vecs[v].ticks);
            chk_a(vecs[v].name, int'(vecs[v].msec), int'(vecs[v].sec), int'(vecs[v].min),
                  int'(vecs[v].hour), int'(vecs[v].running));
        end

        // Tick edge together with run/stop while running: counted, then stopped.
        cyc_a(1'b1, 1'b0, 1'b1);
        chk_a("rs_tick_run", 6, 0, 0, 0, 0);
        cyc_a(1'b0, 1'b0, 1'b0);
        // Tick edge together with run/stop while stopped: dropped, then running.
        cyc_a(1'b1, 1'b0, 1'b1);
        chk_a("rs_tick_stop", 6, 0, 0, 0, 1);
        cyc_a(1'b0, 1'b0, 1'b0);

        // Held-high tick counts once.
        for (int i = 0; i < 20; i++) cyc_a(1'b0, 1'b0, 1'b1);
        cyc_a(1'b0, 1'b0, 1'b0);
        chk_a("held_tick", 7, 0, 0, 0, 1);

        ticks_a(6226);
        chk_a("t_01_02_33", 33, 2, 1, 0, 1);

        // Asynchronous reset between clock edges.
        #2 rst_n = 1'b0;
        #1 chk_a("async_rst", 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        ticks_a(10);
        chk_a("post_rst_idle", 0, 0, 0, 0, 0);
        cyc_a(1'b1, 1'b0, 1'b0);
        cyc_a(1'b0, 1'b0, 1'b0);
        ticks_a(3);
        chk_a("post_rst_run", 3, 0, 0, 0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
